counter_load_updn: RTL and testbench

Parametrised successor to the team's 4-bit loadable counter. It adds a configurable width and modulus, up/down direction, and three run modes: wrap, saturate and one-shot. It also provides a terminal-count pulse and a sticky overflow flag. It is a drop-in timing/event counter for control paths that need a preset start value and a bounded range.

---
 rtl/counter_load_pkg.sv | 13 +
 rtl/counter_load_next.sv | 54 +++++
 rtl/counter_load_updn.sv | 76 +++++++
 tb/tb_counter_load_updn.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/counter_load_pkg.sv
// Shared mode and FSM encodings for the loadable up/down counter.
// Imported by counter_load_next and counter_load_updn.
package counter_load_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

endpackage

// File: rtl/counter_load_next.sv
// Next-count datapath: one step up or down, with wrap or saturate at the bounds.
// Purely combinational; no flow control.
module counter_load_next
  import counter_load_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_count,
  output logic             hit_t,
  output logic             wrap_or_sat
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  assign cnt_x = {1'b0, count};
  assign inc   = cnt_x + 1'b1;
  assign dec   = cnt_x - 1'b1;

  // The extra top bit flags a step outside 0..MAX_VAL, i.e. an attempt to pass T.
  always_comb begin
    next_count  = count;
    hit_t       = 1'b0;
    wrap_or_sat = 1'b0;
    if (mode != MODE_HOLD) begin
      if (up_dn) begin
        if (inc > MAX_X) begin
          wrap_or_sat = 1'b1;
          next_count  = (mode == MODE_WRAP) ? '0 : count;
        end else begin
          next_count = inc[WIDTH-1:0];
          hit_t      = (inc == MAX_X);
        end
      end else begin
        if (dec[WIDTH]) begin
          wrap_or_sat = 1'b1;
          next_count  = (mode == MODE_WRAP) ? MAX_W : count;
        end else begin
          next_count = dec[WIDTH-1:0];
          hit_t      = (dec == '0);
        end
      end
    end
  end

endmodule

// File: rtl/counter_load_updn.sv
// Loadable up/down counter with wrap/saturate/one-shot modes, tc pulse and sticky ovf.
// All outputs registered, 1-cycle latency; no backpressure (every enabled edge steps).
module counter_load_updn
  import counter_load_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_h,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [0:0]       state;
  logic [WIDTH-1:0] next_count;
  logic             hit_t;
  logic             wrap_or_sat;
  logic [WIDTH-1:0] load_clamped;
  logic             step_go;

  counter_load_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count       (count),
    .up_dn       (up_dn),
    .mode        (mode),
    .next_count  (next_count),
    .hit_t       (hit_t),
    .wrap_or_sat (wrap_or_sat)
  );

  assign load_clamped = (load_h > MAX_W) ? MAX_W : load_h;
  assign step_go      = en && !load && (state == ST_RUN) && (mode != MODE_HOLD);
  assign done         = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      state <= ST_RUN;
    end else begin
      ovf <= (ovf && !clr_ovf) || (step_go && wrap_or_sat);
      if (load) begin
        count <= load_clamped;
        tc    <= 1'b0;
        state <= ST_RUN;
      end else if (state == ST_DONE) begin
        // Leaving one-shot mode releases DONE; the edge that does so does not step.
        tc <= 1'b0;
        if (mode != MODE_ONESHOT) state <= ST_RUN;
      end else if (en && mode == MODE_HOLD) begin
        tc <= tc;
      end else if (step_go) begin
        count <= next_count;
        tc    <= hit_t;
        if (mode == MODE_ONESHOT && hit_t) state <= ST_DONE;
      end else begin
        tc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_load_updn.sv
// Directed self-checking bench for counter_load_updn with WIDTH=4, MAX_VAL=9.
module tb_counter_load_updn;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_h = '0;
  logic       up_dn = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       clr_ovf = 1'b0;
  logic [3:0] count;
  logic       tc;
  logic       ovf;
  logic       done;

  int checks = 0;
  int errors = 0;

  counter_load_updn #(.WIDTH(4), .MAX_VAL(9)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_h  (load_h),
    .up_dn   (up_dn),
    .mode    (mode),
    .clr_ovf (clr_ovf),
    .count   (count),
    .tc      (tc),
    .ovf     (ovf),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic t,
                         input logic o, input logic d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    chk({tag, ".ovf"},   32'(ovf),   32'(o));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    #3;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Wrap up from 8
    load = 1'b1; load_h = 4'd8; mode = 2'b00; up_dn = 1'b1;
    tick();
    load = 1'b0;
    chk_all("wrap_load8", 4'd8, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk_all("wrap_s1", 4'd9, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("wrap_s2", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("wrap_s3", 4'd1, 1'b0, 1'b1, 1'b0);
    en = 1'b0;

    // Load clamp and load-over-enable priority
    load = 1'b1; en = 1'b1; load_h = 4'd15;
    tick();
    load = 1'b0; en = 1'b0;
    chk_all("clamp", 4'd9, 1'b0, 1'b1, 1'b0);

    // ovf set wins over clear on a wrap, then clear alone
    en = 1'b1; clr_ovf = 1'b1;
    tick(); chk_all("ovf_set_wins", 4'd0, 1'b0, 1'b1, 1'b0);
    en = 1'b0;
    tick(); chk_all("ovf_clear", 4'd0, 1'b0, 1'b0, 1'b0);
    clr_ovf = 1'b0;

    // Saturate down from 1
    load = 1'b1; load_h = 4'd1; mode = 2'b01; up_dn = 1'b0;
    tick();
    load = 1'b0;
    chk_all("sat_load1", 4'd1, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk_all("sat_s1", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("sat_s2", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("sat_s3", 4'd0, 1'b0, 1'b1, 1'b0);
    en = 1'b0;
    clr_ovf = 1'b1;
    tick(); chk_all("sat_idle_clr", 4'd0, 1'b0, 1'b0, 1'b0);
    clr_ovf = 1'b0;

    // One-shot up from 7
    load = 1'b1; load_h = 4'd7; mode = 2'b10; up_dn = 1'b1;
    tick();
    load = 1'b0;
    chk_all("os_load7", 4'd7, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk_all("os_s1", 4'd8, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("os_s2", 4'd9, 1'b1, 1'b0, 1'b1);
    tick(); chk_all("os_s3", 4'd9, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("os_s4", 4'd9, 1'b0, 1'b0, 1'b1);
    load = 1'b1; load_h = 4'd3;
    tick(); chk_all("os_reload", 4'd3, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    tick(); chk_all("os_rerun", 4'd4, 1'b0, 1'b0, 1'b0);

    // Leaving one-shot mode releases DONE
    load = 1'b1; load_h = 4'd8;
    tick();
    load = 1'b0;
    tick(); chk_all("os_done_again", 4'd9, 1'b1, 1'b0, 1'b1);
    en = 1'b0; mode = 2'b00;
    tick(); chk_all("os_mode_exit", 4'd9, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges, mid one-shot
    load = 1'b1; load_h = 4'd5; mode = 2'b10; up_dn = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    chk_all("ar_load5", 4'd5, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("ar_step", 4'd4, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("ar_async", 4'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    #2 rst = 1'b0;
    tick(); chk_all("ar_hold", 4'd0, 1'b0, 1'b0, 1'b0);

    // First edge after reset steps; wrap down from 0
    en = 1'b1; mode = 2'b00;
    tick(); chk_all("ar_first_step", 4'd9, 1'b0, 1'b1, 1'b0);
    en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
